// File: rtl/game_pkg.sv
// Constants and conversion FSM encoding shared by the BCD<->binary converters.
package game_pkg;

  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ        = 4'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit after a right shift.
module bcd_digit_adjust
  import game_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit - BCD_ADJ) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Multicycle packed-BCD to binary converter: one shift-and-correct step per clock,
// start/done handshake, err flags any digit above 9.
module bcd_to_bin_seq
  import game_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_bcd_in,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BIN_W-1:0]      o_bin_out,
  output logic                  o_err
);

  localparam int unsigned SR_W  = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SR_W - 1);

  conv_state_e       r_state, w_state_next;
  logic [SR_W-1:0]   r_sr_bcd, w_sr_bcd_next;
  logic [SR_W-1:0]   r_sr_bin, w_sr_bin_next;
  logic [SR_W-1:0]   w_bcd_shifted, w_bcd_adj;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [BIN_W-1:0]  r_bin_out, w_bin_out_next;
  logic              r_err, w_err_next;
  logic              w_bad_digit;

  assign w_bcd_shifted = r_sr_bcd >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (w_bcd_shifted[4*g +: 4]),
      .o_digit (w_bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    w_bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i_bcd_in[4*i +: 4] > BCD_DIGIT_MAX) w_bad_digit = 1'b1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_sr_bcd_next  = r_sr_bcd;
    w_sr_bin_next  = r_sr_bin;
    w_cnt_next     = r_cnt;
    w_bin_out_next = r_bin_out;
    w_err_next     = r_err;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_sr_bcd_next = i_bcd_in;
          w_sr_bin_next = '0;
          w_cnt_next    = '0;
          if (w_bad_digit) begin
            w_state_next   = StDone;
            w_err_next     = 1'b1;
            w_bin_out_next = '0;
          end else begin
            w_state_next = StShift;
          end
        end
      end
      StShift: begin
        w_sr_bcd_next = w_bcd_adj;
        w_sr_bin_next = {r_sr_bcd[0], r_sr_bin[SR_W-1:1]};
        w_cnt_next    = r_cnt + CNT_W'(1);
        // Result is registered on the last step so it is valid during the done cycle.
        if (r_cnt == LAST_STEP) begin
          w_state_next   = StDone;
          w_bin_out_next = w_sr_bin_next[BIN_W-1:0];
          w_err_next     = 1'b0;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_sr_bcd  <= '0;
      r_sr_bin  <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sr_bcd  <= w_sr_bcd_next;
      r_sr_bin  <= w_sr_bin_next;
      r_cnt     <= w_cnt_next;
      r_bin_out <= w_bin_out_next;
      r_err     <= w_err_next;
    end
  end

  assign o_ready   = (r_state == StIdle);
  assign o_busy    = (r_state == StShift) || (r_state == StDone);
  assign o_done    = (r_state == StDone);
  assign o_bin_out = r_bin_out;
  assign o_err     = r_err;

endmodule
